// File: rtl/coreriscv_axi4_id_tracker.sv
// Per-ID outstanding-transaction tracker with issue throttling and fence drain for the CoreRISCV AXI4 master port.
// Optional: define CORERISCV_AXI4_ID_TRACKER_ERR_EN to enable unmatched-response detection and the sticky error flag.
module coreriscv_axi4_id_tracker #(
  parameter int IN_ID_W  = 2,
  parameter int OUT_ID_W = 5,
  parameter int MAX_OUT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic [IN_ID_W-1:0]  io_req_in_id,
  output logic [OUT_ID_W-1:0] io_req_out_id,
  input  logic                io_resp_valid,
  input  logic [OUT_ID_W-1:0] io_resp_out_id,
  output logic [IN_ID_W-1:0]  io_resp_in_id,
  output logic                io_resp_matches,
  input  logic                io_fence_req,
  output logic                io_fence_done,
  output logic                io_busy,
  output logic                io_err_unmatched
);

  localparam int N_IDS = 1 << IN_ID_W;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                 r_state;
  logic                   r_fence_done;
  logic [N_IDS-1:0][2:0]  r_cnt;

  logic [N_IDS-1:0]       w_inc;
  logic [N_IDS-1:0]       w_dec;
  logic [N_IDS-1:0]       w_nz;
  logic [2:0]             w_cnt_req;
  logic [2:0]             w_cnt_resp;
  logic                   w_fire;
  logic                   w_hit;
  logic                   w_busy;

  assign io_req_out_id = OUT_ID_W'(io_req_in_id);
  assign io_resp_in_id = io_resp_out_id[IN_ID_W-1:0];

  assign w_cnt_req  = r_cnt[io_req_in_id];
  assign w_cnt_resp = r_cnt[io_resp_in_id];

  // Ready deliberately ignores a same-cycle response on the same ID.
  assign io_req_ready = (r_state == IDLE) && (w_cnt_req != 3'(MAX_OUT));
  assign w_fire       = io_req_valid & io_req_ready;

`ifdef CORERISCV_AXI4_ID_TRACKER_ERR_EN
  logic w_upper_zero;
  logic r_err;

  assign w_upper_zero     = ((io_resp_out_id >> IN_ID_W) == '0);
  assign io_resp_matches  = w_upper_zero && (w_cnt_resp != 3'd0);
  assign w_hit            = io_resp_valid & io_resp_matches;
  assign io_err_unmatched = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (io_resp_valid && !io_resp_matches) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_resp;

  // Without detection every response counts, but an empty counter must not wrap.
  assign w_unused_resp    = ^io_resp_out_id;
  assign io_resp_matches  = 1'b1;
  assign w_hit            = io_resp_valid && (w_cnt_resp != 3'd0);
  assign io_err_unmatched = 1'b0;
`endif

  for (genvar gi = 0; gi < N_IDS; gi++) begin : g_id
    assign w_inc[gi] = w_fire && (io_req_in_id == IN_ID_W'(gi));
    assign w_dec[gi] = w_hit && (io_resp_in_id == IN_ID_W'(gi));
    assign w_nz[gi]  = (r_cnt[gi] != 3'd0);
  end

  assign w_busy  = |w_nz;
  assign io_busy = w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < N_IDS; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 3'd1;
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - 3'd1;
        end
      end
    end
  end

  // Drain completes one cycle after the registered counters are all seen empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_fence_done <= 1'b0;
    end else begin
      r_fence_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_fence_req) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!w_busy) begin
            r_state      <= DONE;
            r_fence_done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_fence_done = r_fence_done;

endmodule

// File: doc/coreriscv_axi4_id_tracker.md
# coreriscv_axi4_id_tracker

Stateful AXI4 transaction-ID tracker and issue controller for the CoreRISCV AXI4 master port. It sits between the core's request/response ID stream and the AXI4 interconnect, where it takes the place of a stateless ID pass-through. It counts outstanding transactions per input ID and throttles issue when an ID reaches its limit. It flags responses that match no outstanding transaction and sequences a fence (drain) so that all in-flight transactions complete before new ones issue.

## Interface
- IN_ID_W, 2, width of core-side transaction ID
- OUT_ID_W, 5, width of AXI-side ID; must be ≥ IN_ID_W
- MAX_OUT, 4, maximum outstanding transactions per input ID (1..7); counter width 3 bits
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- io_req_valid  in  1  core presents a request
- io_req_ready  out  1  request accepted this cycle when high together with valid
- io_req_in_id  in  IN_ID_W  core-side ID of the request
- io_req_out_id  out  OUT_ID_W  AXI ID, zero-extended io_req_in_id
- io_resp_valid  in  1  AXI response beat completing a transaction (B, or R with last)
- io_resp_out_id  in  OUT_ID_W  AXI ID of the response
- io_resp_in_id  out  IN_ID_W  io_resp_out_id[IN_ID_W-1:0]
- io_resp_matches  out  1  response ID maps to an ID with nonzero outstanding count
- io_fence_req  in  1  request to drain all outstanding transactions
- io_fence_done  out  1  one-cycle pulse when the drain completes
- io_busy  out  1  any counter nonzero
- io_err_unmatched  out  1  sticky: an unmatched response was observed

## Operation
- One counter cnt[i] per input ID, 2^IN_ID_W entries, reset to 0.
- req_fire = io_req_valid & io_req_ready. It increments cnt[io_req_in_id].
- resp_hit = io_resp_valid & io_resp_matches. It decrements cnt[io_resp_in_id].
- A fire and a hit on the same ID in the same cycle leave that counter unchanged. A fire and a hit on different IDs both apply.
- io_req_ready = (state==IDLE) & (cnt[io_req_in_id] != MAX_OUT). It is combinational from registers and the ID only, and does not credit a same-cycle response.
- io_resp_matches = (io_resp_out_id[OUT_ID_W-1:IN_ID_W]==0) & (cnt[io_resp_in_id] != 0).
- io_resp_valid with io_resp_matches low: no counter changes, and io_err_unmatched is set. Only reset clears it.
- io_busy = OR over all cnt[i] != 0.
- Fence FSM, states IDLE, DRAIN, DONE:
  - IDLE → DRAIN when io_fence_req is high. A request presented in that same cycle is still accepted and counted.
  - DRAIN: io_req_ready=0. Go to DONE in the cycle that follows a cycle in which all registered counters are 0.
  - DONE: io_fence_done=1 for exactly one cycle, then IDLE. io_fence_req is ignored outside IDLE.
- Reset mid-operation: all counters are zeroed, the FSM goes to IDLE, and the error flag clears. In-flight transactions are forgotten, and their later responses register as unmatched.

## Timing
- Reset values: io_req_ready=1 (combinational, cnt=0, IDLE), io_fence_done=0, io_busy=0, io_err_unmatched=0, io_resp_matches=0 when out_id upper bits are nonzero.
- Counter and flag updates are visible on the rising edge after the event.
- ID mapping (io_req_out_id, io_resp_in_id) is purely combinational with zero latency.
- Fence with no outstanding transactions: fence_req at cycle 0, DRAIN at cycle 1, DONE with io_fence_done high at cycle 2, IDLE with ready high at cycle 3.
- Fence with outstanding transactions: the last hit is at cycle N, counters are 0 at N+1, io_fence_done is high at N+2.

## Configuration
- CORERISCV_AXI4_ID_TRACKER_ERR_EN defined: unmatched-response detection and the sticky io_err_unmatched are present, as described above.
- CORERISCV_AXI4_ID_TRACKER_ERR_EN undefined: io_resp_matches is tied 1 and io_err_unmatched is tied 0.
  - Every io_resp_valid decrements its counter, saturating at 0.
  - Throttling and the fence FSM are unchanged.

## Test plan
- Issue four requests with in_id=1 (MAX_OUT=4) → io_req_out_id=5'd1 each time. Ready drops for in_id=1 after the fourth, stays high for in_id=2, and io_busy=1.
- In a full in_id=1 state, apply a same-cycle request on in_id=1 plus a response with out_id=1 → the request is refused, and the count drops to 3 on the next cycle. Apply a simultaneous fire and hit on in_id=0 with count 2 → count stays 2.
- Apply a response with out_id=5'd8 → matches=0, io_err_unmatched=1 next cycle, and it remains set. Repeat with ERR_EN undefined → matches=1, no error flag.
- Raise the fence with two outstanding on in_id=3 → ready=0 throughout DRAIN. After the second response, io_fence_done pulses exactly two cycles later, and ready returns the following cycle.
- Raise the fence with nothing outstanding → io_fence_done is high on cycle 2 for one cycle.
- Assert reset during DRAIN with three outstanding → all outputs return to reset values immediately (asynchronously), ready=1, and no io_fence_done pulse occurs.
